rv32i_pipe_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage RV32I core (if/id/ex/mem/wb).
//  - Detects load-use hazards that forwarding cannot cover; inserts a bubble into EX.
//  - Turns the ID-stage jump_enable into an IF/ID flush.
//  - Freezes the pipe while data memory is busy.
//  - Runs the EBREAK drain/halt/resume state machine.

---
 rtl/rv32i_pipe_ctrl.sv | 144 ++++++++++++++
 tb/tb_rv32i_pipe_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_pipe_ctrl.sv
// Pipeline sequencer for a 5-stage RV32I core: load-use bubbles, jump flushes,
// memory-busy freeze and the EBREAK drain/halt/resume state machine.
//
//   state | meaning
//   RUN   | normal issue; hazards and jumps are resolved here
//   DRAIN | EBREAK seen; NOPs are fed into EX until the pipe is empty
//   HALT  | core halted; waiting for resume
module rv32i_pipe_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_iw,
    input  logic [31:0]      ex_iw,
    input  logic [4:0]       ex_wb_reg,
    input  logic             jump_enable,
    input  logic             mem_busy,
    input  logic             resume,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_bubble,
    output logic             ex_stall,
    output logic             id_flush,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_e;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [6:0] id_op;
    logic [4:0] rs1, rs2;
    logic       uses_rs1, uses_rs2, ex_load, lu, ebrk;
    logic       unused_ex_bits;

    assign id_op    = id_iw[6:0];
    assign rs1      = id_iw[19:15];
    assign rs2      = id_iw[24:20];
    assign uses_rs1 = !((id_op == 7'b0110111) || (id_op == 7'b0010111) || (id_op == 7'b1101111));
    assign uses_rs2 = (id_op == 7'b0110011) || (id_op == 7'b0100011) || (id_op == 7'b1100011);
    assign ex_load  = (ex_iw[6:0] == 7'b0000011);
    assign lu       = ex_load && (ex_wb_reg != 5'd0) &&
                      ((uses_rs1 && (rs1 == ex_wb_reg)) || (uses_rs2 && (rs2 == ex_wb_reg)));
    assign ebrk     = (id_iw == 32'h0010_0073);
    assign unused_ex_bits = ^ex_iw[31:7];

    logic if_stall_c, id_stall_c, ex_bubble_c, ex_stall_c, id_flush_c, halted_c;

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        if_stall_c  = 1'b0;
        id_stall_c  = 1'b0;
        ex_bubble_c = 1'b0;
        ex_stall_c  = 1'b0;
        id_flush_c  = 1'b0;
        halted_c    = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    if_stall_c = 1'b1;
                    id_stall_c = 1'b1;
                    ex_stall_c = 1'b1;
                end else if (lu) begin
                    if_stall_c  = 1'b1;
                    id_stall_c  = 1'b1;
                    ex_bubble_c = 1'b1;
                end else if (ebrk) begin
                    if_stall_c  = 1'b1;
                    id_stall_c  = 1'b1;
                    ex_bubble_c = 1'b1;
                    state_d     = DRAIN;
                    drain_d     = DRAIN_LOAD;
                end else if (jump_enable) begin
                    id_flush_c = 1'b1;
                end
            end
            DRAIN: begin
                if_stall_c = 1'b1;
                id_stall_c = 1'b1;
                if (mem_busy) begin
                    ex_stall_c = 1'b1;
                end else begin
                    ex_bubble_c = 1'b1;
                    if (drain_q == '0) state_d = HALT;
                    else               drain_d = drain_q - DW'(1);
                end
            end
            HALT: begin
                halted_c    = 1'b1;
                ex_bubble_c = 1'b1;
                if (resume) begin
                    // EBREAK is discarded and the PC moves past it
                    id_flush_c = 1'b1;
                    state_d    = RUN;
                end else begin
                    if_stall_c = 1'b1;
                    id_stall_c = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (if_stall_c && (state_q != HALT) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            drain_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
        end
    end

    // Async reset must silence every control output immediately
    assign if_stall  = reset & if_stall_c;
    assign id_stall  = reset & id_stall_c;
    assign ex_bubble = reset & ex_bubble_c;
    assign ex_stall  = reset & ex_stall_c;
    assign id_flush  = reset & id_flush_c;
    assign halted    = reset & halted_c;
    assign state     = state_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// Randomized and directed bench for rv32i_pipe_ctrl against a rule-level model.
module tb_rv32i_pipe_ctrl;

    localparam int DRAIN_CYCLES = 3;
    localparam int CNT_MAX      = 65535;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] EBRK  = 32'h0010_0073;
    localparam logic [31:0] LW_X5 = 32'h0000_A283;   // lw  x5,0(x1)
    localparam logic [31:0] ADD_U = 32'h0072_8333;   // add x6,x5,x7
    localparam logic [31:0] ADD_0 = 32'h0070_0333;   // add x6,x0,x7
    localparam logic [31:0] LUI_5 = 32'h0002_82B7;   // lui x5 (rs1 field = 5)

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] id_iw, ex_iw;
    logic [4:0]  ex_wb_reg;
    logic        jump_enable, mem_busy, resume;
    logic        if_stall, id_stall, ex_bubble, ex_stall, id_flush, halted;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    rv32i_pipe_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .id_iw(id_iw), .ex_iw(ex_iw), .ex_wb_reg(ex_wb_reg),
        .jump_enable(jump_enable), .mem_busy(mem_busy), .resume(resume),
        .if_stall(if_stall), .id_stall(id_stall), .ex_bubble(ex_bubble), .ex_stall(ex_stall),
        .id_flush(id_flush), .halted(halted), .state(state), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: mode 0=run 1=drain 2=halt; left = drain cycles still to serve
    int m_mode, m_left, m_cnt, n_mode, n_left;
    bit e_if, e_id, e_bub, e_exs, e_fl, e_halt;

    function automatic bit load_use();
        logic [6:0] op;
        bit r1, r2;
        op = id_iw[6:0];
        r1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        r2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return (ex_iw[6:0] == 7'b0000011) && (ex_wb_reg != 0) &&
               ((r1 && id_iw[19:15] == ex_wb_reg) || (r2 && id_iw[24:20] == ex_wb_reg));
    endfunction

    function automatic void model_eval();
        {e_if, e_id, e_bub, e_exs, e_fl, e_halt} = '0;
        n_mode = m_mode;
        n_left = m_left;
        if (m_mode == 2) begin
            e_halt = 1; e_bub = 1;
            if (resume) begin e_fl = 1; n_mode = 0; end
            else begin e_if = 1; e_id = 1; end
        end else if (mem_busy) begin
            e_if = 1; e_id = 1; e_exs = 1;
        end else if (m_mode == 1) begin
            e_if = 1; e_id = 1; e_bub = 1;
            n_left = m_left - 1;
            if (n_left == 0) n_mode = 2;
        end else if (load_use()) begin
            e_if = 1; e_id = 1; e_bub = 1;
        end else if (id_iw == EBRK) begin
            e_if = 1; e_id = 1; e_bub = 1;
            n_mode = 1; n_left = DRAIN_CYCLES;
        end else if (jump_enable) begin
            e_fl = 1;
        end
    endfunction

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_cnt = 0;
    endtask

    task automatic set_idle();
        id_iw = NOP; ex_iw = NOP; ex_wb_reg = 0;
        jump_enable = 0; mem_busy = 0; resume = 0;
    endtask

    // Entered just after a negedge with inputs already applied; exits on the next negedge.
    task automatic run_cycle();
        #2;
        model_eval();
        chk("if_stall", 32'(if_stall), 32'(e_if));
        chk("id_stall", 32'(id_stall), 32'(e_id));
        chk("ex_bubble", 32'(ex_bubble), 32'(e_bub));
        chk("ex_stall", 32'(ex_stall), 32'(e_exs));
        chk("id_flush", 32'(id_flush), 32'(e_fl));
        chk("halted", 32'(halted), 32'(e_halt));
        chk("state", 32'(state), 32'(m_mode));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        @(posedge clk);
        if (e_if && m_mode != 2 && m_cnt < CNT_MAX) m_cnt++;
        m_mode = n_mode;
        m_left = n_left;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 0;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1;
    endtask

    function automatic logic [31:0] rand_iw();
        logic [6:0] ops [10];
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0100011,
                7'b1100011, 7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011};
        return {7'b0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'b0,
                5'($urandom_range(0, 7)), ops[$urandom_range(0, 9)]};
    endfunction

    int cyc;

    initial begin
        set_idle();
        id_iw = ADD_U; ex_iw = LW_X5; ex_wb_reg = 5;
        reset = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #2;
        chk("rst_if_stall", 32'(if_stall), 0);
        chk("rst_ex_bubble", 32'(ex_bubble), 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        reset = 1;

        // Load-use
        run_cycle();
        chk("lu_cnt_after", 32'(stall_cnt), 1);
        set_idle();
        run_cycle();

        // No false hazards
        ex_iw = LW_X5; ex_wb_reg = 0; id_iw = ADD_0;
        #2 chk("nohz_x0", 32'(if_stall), 0);
        run_cycle();
        ex_wb_reg = 5; id_iw = LUI_5;
        #2 chk("nohz_lui", 32'(if_stall), 0);
        run_cycle();

        // Jump, then jump masked by load-use
        set_idle(); jump_enable = 1;
        #2 chk("jmp_flush", 32'(id_flush), 1);
        run_cycle();
        id_iw = ADD_U; ex_iw = LW_X5; ex_wb_reg = 5;
        #2 chk("jmp_lu_flush", 32'(id_flush), 0);
        chk("jmp_lu_bubble", 32'(ex_bubble), 1);
        run_cycle();

        // EBREAK drain and halt
        set_idle(); id_iw = EBRK;
        for (int i = 0; i < 5; i++) begin
            #1 chk("ebrk_state_seq", 32'(state), (i == 0) ? 0 : (i == 4) ? 2 : 1);
            #1 chk("ebrk_halted_seq", 32'(halted), (i == 4) ? 1 : 0);
            run_cycle();
            #0;
        end
        chk("halt_hold", 32'(state), 2);
        id_iw = NOP; resume = 1;
        #2 chk("resume_flush", 32'(id_flush), 1);
        run_cycle();
        resume = 0;
        chk("resume_state", 32'(state), 0);

        // mem_busy during DRAIN delays halt by 5 cycles
        id_iw = EBRK;
        run_cycle();
        id_iw = NOP; mem_busy = 1;
        repeat (5) run_cycle();
        mem_busy = 0;
        cyc = 1 + 5;
        while (!halted && cyc < 30) begin
            run_cycle();
            cyc++;
        end
        chk("busy_halt_delay", 32'(cyc), DRAIN_CYCLES + 1 + 5);

        // Async reset in HALT
        #3 reset = 0;
        #1 chk("async_halted", 32'(halted), 0);
        chk("async_state", 32'(state), 0);
        model_reset();
        @(negedge clk);
        reset = 1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            id_iw       = ($urandom_range(0, 19) == 0) ? EBRK : rand_iw();
            ex_iw       = rand_iw();
            ex_wb_reg   = 5'($urandom_range(0, 7));
            jump_enable = ($urandom_range(0, 3) == 0);
            mem_busy    = ($urandom_range(0, 5) == 0);
            resume      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            run_cycle();
        end

        // Counter saturation
        do_reset();
        set_idle();
        id_iw = ADD_U; ex_iw = LW_X5; ex_wb_reg = 5;
        repeat (70000) @(negedge clk);
        m_cnt = (m_cnt + 70000 > CNT_MAX) ? CNT_MAX : m_cnt + 70000;
        chk("sat_cnt", 32'(stall_cnt), 32'h0000_FFFF);
        run_cycle();
        chk("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
